cell_sequencer: RTL and testbench

CELL_SEQUENCER -- requirements
Module: cell_sequencer

---
 rtl/cell_sequencer.sv | 138 +++++++++++++
 tb/tb_cell_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_sequencer.sv
// Cell sequencer: on frame_start, walks descriptor cells 0..nCells-1, offers each
// non-empty cell downstream over valid/ready, and shares the memory with host writes.
module cell_sequencer #(
    parameter int nCells     = 8,
    parameter int WORD_SIZE  = 32,
    parameter int SKIP_EMPTY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic                      host_we,
    input  logic [$clog2(nCells)-1:0] host_addr,
    input  logic [WORD_SIZE-1:0]      host_data,
    output logic                      host_ack,
    output logic                      mem_we,
    output logic [nCells-1:0]         mem_ptr,
    output logic [$clog2(nCells)-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]      mem_din,
    input  logic [WORD_SIZE-1:0]      mem_dout,
    output logic                      desc_valid,
    input  logic                      desc_ready,
    output logic [WORD_SIZE-1:0]      desc_data,
    output logic [$clog2(nCells)-1:0] desc_idx,
    output logic                      busy,
    output logic                      scan_done
);
    typedef enum logic [1:0] {IDLE, FETCH, OFFER, DONE} state_t;

    localparam int AW = $clog2(nCells);
    localparam logic [AW-1:0] LAST_IDX = AW'(nCells - 1);

    state_t               state_reg;
    logic [AW-1:0]        idx_reg;
    logic                 pending_reg;
    logic [WORD_SIZE-1:0] desc_data_reg;
    logic [AW-1:0]        desc_idx_reg;
    logic                 desc_valid_reg;
    logic                 busy_reg;
    logic                 scan_done_reg;

    logic cell_empty;
    logic at_last;
    logic grant;

    // The top nibble is a tag; a cell whose body below it is zero carries no work.
    assign cell_empty = (SKIP_EMPTY != 0) && (mem_dout[WORD_SIZE-5:0] == '0);
    assign at_last    = (idx_reg == LAST_IDX);
    // FETCH is the cycle the descriptor is captured, so host writes are held off then.
    assign grant      = host_we && (state_reg != FETCH) && !rst;

    assign host_ack = grant;
    assign mem_we   = grant;
    assign mem_din  = host_data;
    assign mem_addr = idx_reg;

    // Out-of-range host addresses match no bit, so the write is acknowledged but dropped.
    for (genvar gi = 0; gi < nCells; gi++) begin : g_ptr
        assign mem_ptr[gi] = grant && (host_addr == AW'(gi));
    end

    assign desc_valid = desc_valid_reg;
    assign desc_data  = desc_data_reg;
    assign desc_idx   = desc_idx_reg;
    assign busy       = busy_reg;
    assign scan_done  = scan_done_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            pending_reg    <= 1'b0;
            desc_data_reg  <= '0;
            desc_idx_reg   <= '0;
            desc_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            scan_done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (frame_start) begin
                        state_reg <= FETCH;
                        idx_reg   <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                FETCH: begin
                    desc_data_reg <= mem_dout;
                    desc_idx_reg  <= idx_reg;
                    if (frame_start) begin
                        pending_reg <= 1'b1;
                    end
                    if (!cell_empty) begin
                        state_reg      <= OFFER;
                        desc_valid_reg <= 1'b1;
                    end else if (at_last) begin
                        state_reg     <= DONE;
                        scan_done_reg <= 1'b1;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                OFFER: begin
                    if (frame_start) begin
                        pending_reg <= 1'b1;
                    end
                    if (desc_ready) begin
                        desc_valid_reg <= 1'b0;
                        if (at_last) begin
                            state_reg     <= DONE;
                            scan_done_reg <= 1'b1;
                        end else begin
                            state_reg <= FETCH;
                            idx_reg   <= idx_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    scan_done_reg <= 1'b0;
                    idx_reg       <= '0;
                    // A frame_start landing in this very cycle merges into the restart.
                    if (pending_reg || frame_start) begin
                        state_reg   <= FETCH;
                        pending_reg <= 1'b0;
                    end else begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    busy_reg       <= 1'b0;
                    desc_valid_reg <= 1'b0;
                    scan_done_reg  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cell_sequencer.sv
// Bench for cell_sequencer: one instance skips empty cells, one offers all cells;
// a transaction-level scan model is compared against both every cycle.
module tb_cell_sequencer;
    localparam int N = 8;
    localparam int W = 32;
    localparam logic [W-1:0] DEF [N] = '{32'h1000_0010, 32'h2000_0000, 32'h3000_00F0, 32'h4000_0033,
                                         32'h5000_0044, 32'h6000_0055, 32'h7000_0066, 32'hF000_0000};

    typedef struct {
        bit           done;
        int           idx;
        logic [W-1:0] data;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst         = 1'b1;
    logic         frame_start = 1'b0;
    logic         host_we     = 1'b0;
    logic         desc_ready  = 1'b1;
    logic [2:0]   host_addr   = '0;
    logic [W-1:0] host_data   = '0;

    logic [1:0]        host_ack_w, mem_we_w, desc_valid_w, busy_w, scan_done_w;
    logic [1:0][N-1:0] mem_ptr_w;
    logic [1:0][2:0]   mem_addr_w, desc_idx_w;
    logic [1:0][W-1:0] mem_din_w, mem_dout_w, desc_data_w;

    // Instance 0 skips empty cells, instance 1 offers every cell; each has its own memory core.
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [W-1:0] mem [N];

        cell_sequencer #(.nCells(N), .WORD_SIZE(W), .SKIP_EMPTY(gi == 0 ? 1 : 0)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .frame_start (frame_start),
            .host_we     (host_we),
            .host_addr   (host_addr),
            .host_data   (host_data),
            .host_ack    (host_ack_w[gi]),
            .mem_we      (mem_we_w[gi]),
            .mem_ptr     (mem_ptr_w[gi]),
            .mem_addr    (mem_addr_w[gi]),
            .mem_din     (mem_din_w[gi]),
            .mem_dout    (mem_dout_w[gi]),
            .desc_valid  (desc_valid_w[gi]),
            .desc_ready  (desc_ready),
            .desc_data   (desc_data_w[gi]),
            .desc_idx    (desc_idx_w[gi]),
            .busy        (busy_w[gi]),
            .scan_done   (scan_done_w[gi])
        );

        always @(posedge clk) begin
            if (mem_we_w[gi]) begin
                for (int j = 0; j < N; j++) begin
                    if (mem_ptr_w[gi][j]) mem[j] <= mem_din_w[gi];
                end
            end
        end
        assign mem_dout_w[gi] = mem[mem_addr_w[gi]];
    end

    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           start_cyc = 0;
    int           scans_launched = 0;
    int           stall_left = 0;
    int           consumed [2];
    bit           held [2];
    int           done_cnt [2];
    int           done_cyc [2];
    logic [N-1:0] acc_mask_a;
    logic [W-1:0] acc_data_a [N];
    logic [W-1:0] shadow [N];
    ev_t          exp_q [2][$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected scan: ascending cells, dropping empty bodies where the instance skips them.
    task automatic build_scan(input int k);
        for (int i = 0; i < N; i++) begin
            if (k == 1 || shadow[i][W-5:0] != '0) exp_q[k].push_back('{1'b0, i, shadow[i]});
        end
        exp_q[k].push_back('{1'b1, 0, '0});
    endtask

    task automatic compare_cycle();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                exp_q[k].delete();
                consumed[k] = scans_launched;
                held[k] = 1'b0;
            end else begin
                if (exp_q[k].size() == 0 && consumed[k] < scans_launched) build_scan(k);
                if (desc_valid_w[k]) begin
                    if (exp_q[k].size() == 0 || exp_q[k][0].done) begin
                        checks++;
                        failures++;
                        $display("FAIL desc_unexpected[%0d]: got idx %0d, required no descriptor (cycle %0d)",
                                 k, desc_idx_w[k], cyc);
                    end else begin
                        chk($sformatf("desc_idx[%0d]", k), 64'(desc_idx_w[k]), 64'(exp_q[k][0].idx));
                        chk($sformatf("desc_data[%0d]", k), 64'(desc_data_w[k]), 64'(exp_q[k][0].data));
                        if (desc_ready) begin
                            if (k == 0) begin
                                acc_mask_a[desc_idx_w[0]] = 1'b1;
                                acc_data_a[desc_idx_w[0]] = desc_data_w[0];
                            end
                            void'(exp_q[k].pop_front());
                        end
                    end
                end else if (held[k]) begin
                    checks++;
                    failures++;
                    $display("FAIL desc_dropped[%0d]: got valid 0 while stalled, required 1 (cycle %0d)", k, cyc);
                end
                held[k] = desc_valid_w[k] && !desc_ready;
                if (scan_done_w[k]) begin
                    done_cnt[k]++;
                    done_cyc[k] = cyc;
                    chk($sformatf("scan_done_expected[%0d]", k),
                        64'(exp_q[k].size() > 0 && exp_q[k][0].done), 64'(1));
                    if (exp_q[k].size() > 0 && exp_q[k][0].done) begin
                        void'(exp_q[k].pop_front());
                        consumed[k]++;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic launch();
        frame_start = 1'b1;
        scans_launched++;
        start_cyc = cyc;
        tick();
        frame_start = 1'b0;
    endtask

    // Runs until both instances are idle; also stalls instance 0's offer of cell 2 on request.
    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy_w != 2'b00 && n < budget) begin
            if (stall_left > 0 && desc_valid_w[0] && desc_idx_w[0] == 3'd2) begin
                chk("stall_data", 64'(desc_data_w[0]), 64'(32'h3000_00F0));
                chk("stall_addr", 64'(mem_addr_w[0]), 64'(2));
                desc_ready = 1'b0;
                stall_left--;
            end else begin
                desc_ready = 1'b1;
            end
            tick();
            n++;
        end
        desc_ready = 1'b1;
        if (busy_w != 2'b00) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: got busy %b after %0d cycles, required 00", busy_w, budget);
        end
    endtask

    initial begin
        int d0;
        int d1;
        bit found;

        // Reset with a pending host request: nothing may be granted.
        host_we = 1'b1; host_addr = 3'd5; host_data = 32'hDEAD_BEEF;
        #1;
        chk("rst_host_ack", 64'(host_ack_w[0]), 64'(0));
        chk("rst_mem_we", 64'(mem_we_w[0]), 64'(0));
        tick();
        tick();
        chk("rst_valid", 64'(desc_valid_w[0]), 64'(0));
        chk("rst_busy", 64'(busy_w[0]), 64'(0));
        chk("rst_done", 64'(scan_done_w[0]), 64'(0));
        chk("rst_data", 64'(desc_data_w[0]), 64'(0));
        chk("rst_idx", 64'(desc_idx_w[0]), 64'(0));
        chk("rst_addr", 64'(mem_addr_w[0]), 64'(0));
        chk("rst_ack_held", 64'(host_ack_w[0]), 64'(0));
        host_we = 1'b0;
        rst = 1'b0;

        // Load the default descriptor table through the host port.
        for (int i = 0; i < N; i++) begin
            host_we = 1'b1; host_addr = 3'(i); host_data = DEF[i];
            #1;
            chk("load_ack", 64'(host_ack_w[0]), 64'(1));
            chk("load_ptr", 64'(mem_ptr_w[0]), 64'(1) << i);
            shadow[i] = DEF[i];
            tick();
        end
        host_we = 1'b0;

        // Plain scan: skip instance offers 0,2..6; all-cells instance offers 0..7.
        acc_mask_a = '0; d0 = done_cnt[0]; d1 = done_cnt[1];
        launch();
        chk("s1_busy", 64'(busy_w[0]), 64'(1));
        chk("s1_valid_early", 64'(desc_valid_w[0]), 64'(0));
        tick();
        chk("s1_valid", 64'(desc_valid_w[0]), 64'(1));
        chk("s1_idx", 64'(desc_idx_w[0]), 64'(0));
        chk("s1_data", 64'(desc_data_w[0]), 64'(32'h1000_0010));
        wait_idle(60);
        chk("s1_mask", 64'(acc_mask_a), 64'(8'b0111_1101));
        chk("s1_done_a", 64'(done_cnt[0] - d0), 64'(1));
        chk("s1_done_b", 64'(done_cnt[1] - d1), 64'(1));
        chk("s1_done_cyc_a", 64'(done_cyc[0] - start_cyc), 64'(15));
        chk("s1_done_cyc_b", 64'(done_cyc[1] - start_cyc), 64'(17));
        chk("s1_busy_low", 64'(busy_w[0]), 64'(0));

        // Downstream stall of five cycles on cell 2.
        stall_left = 5;
        launch();
        wait_idle(80);
        chk("s2_stall_used", 64'(stall_left), 64'(0));
        chk("s2_done_cyc_a", 64'(done_cyc[0] - start_cyc), 64'(20));
        chk("s2_done_cyc_b", 64'(done_cyc[1] - start_cyc), 64'(21));

        // Host write arriving during FETCH of cell 3 is deferred by one cycle.
        launch();
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            if (busy_w[0] && !desc_valid_w[0] && !scan_done_w[0] && mem_addr_w[0] == 3'd3) found = 1'b1;
            else tick();
        end
        chk("s3_found_fetch", 64'(found), 64'(1));
        host_we = 1'b1; host_addr = 3'd1; host_data = 32'h1000_00AA;
        #1;
        chk("s3_fetch_ack", 64'(host_ack_w[0]), 64'(0));
        chk("s3_fetch_we", 64'(mem_we_w[0]), 64'(0));
        tick();
        chk("s3_next_ack", 64'(host_ack_w[0]), 64'(1));
        chk("s3_next_ptr", 64'(mem_ptr_w[0]), 64'(8'b0000_0010));
        tick();
        host_we = 1'b0;
        shadow[1] = 32'h1000_00AA;
        wait_idle(60);
        acc_mask_a = '0;
        launch();
        wait_idle(60);
        chk("s4_mask", 64'(acc_mask_a), 64'(8'b0111_1111));
        chk("s4_cell1", 64'(acc_data_a[1]), 64'(32'h1000_00AA));

        // Two restart pulses mid-scan merge into a single extra scan.
        d0 = done_cnt[0]; d1 = done_cnt[1];
        launch();
        tick(); tick(); tick();
        frame_start = 1'b1; scans_launched++;
        tick();
        frame_start = 1'b0;
        tick(); tick(); tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wait_idle(120);
        chk("s5_done_a", 64'(done_cnt[0] - d0), 64'(2));
        chk("s5_done_b", 64'(done_cnt[1] - d1), 64'(2));

        // A pulse in the DONE cycle itself also restarts.
        d0 = done_cnt[0];
        launch();
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            if (scan_done_w[0]) found = 1'b1;
            else tick();
        end
        chk("s6_found_done", 64'(found), 64'(1));
        frame_start = 1'b1; scans_launched++;
        tick();
        frame_start = 1'b0;
        chk("s6_restart_busy", 64'(busy_w[0]), 64'(1));
        wait_idle(120);
        chk("s6_done_a", 64'(done_cnt[0] - d0), 64'(2));

        // Reset while offering cell 4, then an immediate new frame.
        launch();
        found = 1'b0;
        for (int n = 0; n < 30 && !found; n++) begin
            if (desc_valid_w[0] && desc_idx_w[0] == 3'd4) found = 1'b1;
            else tick();
        end
        chk("s7_found_offer4", 64'(found), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s7_valid", 64'(desc_valid_w[0]), 64'(0));
        chk("s7_data", 64'(desc_data_w[0]), 64'(0));
        chk("s7_idx", 64'(desc_idx_w[0]), 64'(0));
        chk("s7_busy", 64'(busy_w[0]), 64'(0));
        chk("s7_done", 64'(scan_done_w[0]), 64'(0));
        chk("s7_addr", 64'(mem_addr_w[0]), 64'(0));
        d0 = done_cnt[0];
        launch();
        chk("s7_restart_busy", 64'(busy_w[0]), 64'(1));
        chk("s7_restart_addr", 64'(mem_addr_w[0]), 64'(0));
        tick();
        chk("s7_restart_valid", 64'(desc_valid_w[0]), 64'(1));
        chk("s7_restart_idx", 64'(desc_idx_w[0]), 64'(0));
        wait_idle(60);
        chk("s7_done_a", 64'(done_cnt[0] - d0), 64'(1));

        tick();
        chk("end_queue_a", 64'(exp_q[0].size()), 64'(0));
        chk("end_queue_b", 64'(exp_q[1].size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
